// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared FSM state and tag types for the multicast tag generator
package mc_pkg;

    localparam int MC_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

    typedef struct packed {
        logic [MC_ID_WIDTH-1:0] row_id;
        logic [MC_ID_WIDTH-1:0] col_id;
    } mc_tag_t;

    // Same comparison the multicasters apply when snooping the bus.
    function automatic logic mc_tag_match(input mc_tag_t a, input mc_tag_t b);
        return (a.row_id == b.row_id) && (a.col_id == b.col_id);
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - nested word/col/row sweep counters with clamped shadow config
module sweep_counter #(
    parameter int NUM_COL   = 4,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 adv_i,
    input  logic [ID_WIDTH-1:0]  cfg_rows_i,
    input  logic [ID_WIDTH-1:0]  cfg_cols_i,
    input  logic [LEN_WIDTH-1:0] cfg_len_i,
    output logic [ID_WIDTH-1:0]  row_cnt_o,
    output logic [ID_WIDTH-1:0]  col_cnt_o,
    output logic                 last_o
);

    localparam logic [ID_WIDTH-1:0] MAX_COLS = ID_WIDTH'(NUM_COL);

    logic [ID_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [ID_WIDTH-1:0]  row_q, row_d, col_q, col_d;
    logic [LEN_WIDTH-1:0] word_q, word_d;
    logic [ID_WIDTH-1:0]  rows_c, cols_c;
    logic [LEN_WIDTH-1:0] len_c;
    logic                 word_last, col_last, row_last;

    // A zero count still means one destination; columns cannot exceed the bus.
    assign rows_c = (cfg_rows_i == '0) ? ID_WIDTH'(1) : cfg_rows_i;
    assign cols_c = (cfg_cols_i == '0) ? ID_WIDTH'(1)
                  : (cfg_cols_i > MAX_COLS) ? MAX_COLS : cfg_cols_i;
    assign len_c  = (cfg_len_i == '0) ? LEN_WIDTH'(1) : cfg_len_i;

    assign word_last = (word_q == len_q - LEN_WIDTH'(1));
    assign col_last  = (col_q == cols_q - ID_WIDTH'(1));
    assign row_last  = (row_q == rows_q - ID_WIDTH'(1));
    assign last_o    = word_last & col_last & row_last;

    assign row_cnt_o = row_q;
    assign col_cnt_o = col_q;

    always_comb begin
        rows_d = rows_q;
        cols_d = cols_q;
        len_d  = len_q;
        row_d  = row_q;
        col_d  = col_q;
        word_d = word_q;
        if (load_i) begin
            rows_d = rows_c;
            cols_d = cols_c;
            len_d  = len_c;
            row_d  = '0;
            col_d  = '0;
            word_d = '0;
        end else if (adv_i) begin
            word_d = word_last ? '0 : word_q + LEN_WIDTH'(1);
            if (word_last) begin
                col_d = col_last ? '0 : col_q + ID_WIDTH'(1);
                if (col_last) begin
                    row_d = row_last ? '0 : row_q + ID_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q <= '0;
            cols_q <= '0;
            len_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            word_q <= '0;
        end else begin
            rows_q <= rows_d;
            cols_q <= cols_d;
            len_q  <= len_d;
            row_q  <= row_d;
            col_q  <= col_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mc_tag_gen.sv
// rtl/mc_tag_gen.sv - stamps global-buffer words with row/col tags for the multicast bus
module mc_tag_gen
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic [ID_WIDTH-1:0]   cfg_rows,
    input  logic [ID_WIDTH-1:0]   cfg_cols,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [ID_WIDTH-1:0]   bus_row_id,
    output logic [ID_WIDTH-1:0]   bus_col_id,
    output logic                  bus_valid,
    input  logic                  bus_ready
);

    mc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic                  valid_q, valid_d;
    logic [ID_WIDTH-1:0]   row_cnt, col_cnt;
    logic                  sweep_last;
    logic                  load, accept;

    assign load     = (state_q == IDLE) & cfg_start;
    assign in_ready = (state_q == RUN) & (~valid_q | bus_ready);
    assign accept   = in_valid & in_ready;

    sweep_counter #(
        .NUM_COL   (NUM_COL),
        .ID_WIDTH  (ID_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_sweep (
        .clk        (clk),
        .rst        (rstn),
        .load_i     (load),
        .adv_i      (accept),
        .cfg_rows_i (cfg_rows),
        .cfg_cols_i (cfg_cols),
        .cfg_len_i  (cfg_len),
        .row_cnt_o  (row_cnt),
        .col_cnt_o  (col_cnt),
        .last_o     (sweep_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = RUN;
            RUN:     if (accept && sweep_last) state_d = DRAIN;
            DRAIN:   if (!valid_q || bus_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reload on acceptance even while handshaking, so the bus sees one word per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
            row_d   = row_cnt;
            col_d   = col_cnt;
        end else if (bus_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign busy       = (state_q == RUN) | (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign bus_valid  = valid_q;
    assign bus_data   = data_q;
    assign bus_row_id = row_q;
    assign bus_col_id = col_q;

endmodule

// File: tb/tb_mc_tag_gen.sv
// tb/tb_mc_tag_gen.sv - self-checking bench for mc_tag_gen
module tb_mc_tag_gen;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 4;
    localparam int LW = 8;

    logic          clk;
    logic          rstn;
    logic          cfg_start;
    logic [IW-1:0] cfg_rows;
    logic [IW-1:0] cfg_cols;
    logic [LW-1:0] cfg_len;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] bus_data;
    logic [IW-1:0] bus_row_id;
    logic [IW-1:0] bus_col_id;
    logic          bus_valid;
    logic          bus_ready;

    mc_tag_gen #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_start  (cfg_start),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bus_data   (bus_data),
        .bus_row_id (bus_row_id),
        .bus_col_id (bus_col_id),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int cols;
        int len;
        int rdy_mode;
        int val_mode;
        int start_mid;
        int exp_words;
        int exp_done;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
    } word_t;

    int    checks = 0;
    int    failures = 0;
    word_t exp_q[$];
    vec_t  tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_sweep(input int rows, input int cols, input int len,
                             input int rdy_mode, input int val_mode, input int start_mid,
                             input int reset_after, input int exp_words, input int exp_done);
        int            r_eff, c_eff, l_eff, total, k;
        int            acc, hs, cyc, last_hs, starve, done_cnt;
        logic [DW-1:0] base;
        logic          stall;
        logic [DW-1:0] p_data;
        logic [IW-1:0] p_row, p_col;
        word_t         w;
        r_eff = (rows == 0) ? 1 : rows;
        c_eff = (cols == 0) ? 1 : ((cols > NC) ? NC : cols);
        l_eff = (len == 0) ? 1 : len;
        total = r_eff * c_eff * l_eff;
        base  = DW'($urandom);
        exp_q.delete();
        k = 0;
        for (int r = 0; r < r_eff; r++)
            for (int c = 0; c < c_eff; c++)
                for (int i = 0; i < l_eff; i++) begin
                    w.data = base + DW'(k);
                    w.row  = r;
                    w.col  = c;
                    exp_q.push_back(w);
                    k++;
                end
        acc = 0; hs = 0; cyc = 0; last_hs = -10; starve = 0; done_cnt = 0;
        stall = 1'b0; p_data = '0; p_row = '0; p_col = '0;
        forever begin
            @(posedge clk);
            #1;
            cfg_start = (cyc == 0) || (start_mid != 0 && cyc == 3);
            if (cyc == 0) begin
                cfg_rows = IW'(rows);
                cfg_cols = IW'(cols);
                cfg_len  = LW'(len);
            end else begin
                cfg_rows = IW'($urandom);
                cfg_cols = IW'($urandom);
                cfg_len  = LW'($urandom);
            end
            in_valid = (cyc >= 1) && (acc < total);
            if (val_mode == 1 && acc == 4 && starve < 5) begin
                in_valid = 1'b0;
                starve++;
            end
            if (val_mode == 2 && $urandom_range(0, 2) == 0) in_valid = 1'b0;
            in_data = base + DW'(acc);
            if (rdy_mode == 0)      bus_ready = 1'b1;
            else if (rdy_mode == 1) bus_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                    bus_ready = 1'($urandom);
            if (reset_after > 0 && hs == reset_after) begin
                rstn = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_in_ready", 32'(in_ready), 0);
                chk("rst_bus_valid", 32'(bus_valid), 0);
                chk("rst_done", 32'(done), 0);
                @(posedge clk);
                #1;
                rstn = 1'b0;
                cfg_start = 1'b0;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            chk("busy", 32'(busy), 32'((cyc >= 1) && !(hs == total && cyc > last_hs)));
            chk("done", 32'(done), 32'(hs == total && cyc == last_hs + 1));
            chk("bus_valid", 32'(bus_valid), 32'(acc != hs));
            chk("in_ready", 32'(in_ready),
                32'((cyc >= 1) && (acc < total) && ((acc == hs) || bus_ready)));
            if (stall) begin
                chk("stall_data", 32'(bus_data), 32'(p_data));
                chk("stall_row", 32'(bus_row_id), 32'(p_row));
                chk("stall_col", 32'(bus_col_id), 32'(p_col));
            end
            if (bus_valid && bus_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(bus_data), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", 32'(bus_data), 32'(w.data));
                    chk("word_row", 32'(bus_row_id), w.row);
                    chk("word_col", 32'(bus_col_id), w.col);
                end
                hs++;
                last_hs = cyc;
            end
            if (in_valid && in_ready) acc++;
            stall  = bus_valid && !bus_ready;
            p_data = bus_data;
            p_row  = bus_row_id;
            p_col  = bus_col_id;
            if (done) begin
                done_cnt++;
                if (exp_done != 0) chk("done_cycle", cyc, exp_done);
            end
            if (hs >= total && cyc >= last_hs + 4) break;
            cyc++;
            if (cyc > 3000) begin
                chk("timeout_words", hs, total);
                break;
            end
        end
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        chk("word_count", hs, total);
        if (exp_words != 0) chk("word_count_tbl", hs, exp_words);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        rstn = 1'b1;
        cfg_start = 1'b0;
        cfg_rows = '0;
        cfg_cols = '0;
        cfg_len = '0;
        in_data = '0;
        in_valid = 1'b0;
        bus_ready = 1'b0;

        // rows cols len rdy val start_mid words done_cycle
        tbl[0] = '{2, 2, 3, 0, 0, 0, 12, 14};
        tbl[1] = '{2, 2, 3, 1, 0, 0, 12, 0};
        tbl[2] = '{1, 7, 0, 0, 0, 0, 4, 6};
        tbl[3] = '{2, 2, 3, 0, 0, 1, 12, 14};
        tbl[4] = '{2, 2, 3, 0, 1, 0, 12, 19};
        tbl[5] = '{3, 5, 2, 2, 2, 0, 24, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 3};
        tbl[7] = '{4, 1, 5, 1, 2, 0, 20, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_bus_valid", 32'(bus_valid), 0);
        chk("reset_bus_data", 32'(bus_data), 0);
        chk("reset_row", 32'(bus_row_id), 0);
        chk("reset_col", 32'(bus_col_id), 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;

        foreach (tbl[i])
            run_sweep(tbl[i].rows, tbl[i].cols, tbl[i].len, tbl[i].rdy_mode,
                      tbl[i].val_mode, tbl[i].start_mid, 0, tbl[i].exp_words, tbl[i].exp_done);

        run_sweep(2, 2, 3, 0, 0, 0, 5, 0, 0);
        run_sweep(2, 2, 3, 0, 0, 0, 0, 12, 14);

        for (int n = 0; n < 4; n++)
            run_sweep($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 4),
                      2, 2, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
